// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: group lookahead
// function and derived-geometry helpers.
package cla_pkg;

  localparam int MAX_BLOCK = 16;

  typedef struct packed {
    logic                 g;
    logic                 p;
    logic [MAX_BLOCK-1:0] sum;
  } grp_t;

  // Group generate/propagate plus sum for the low n bits.
  function automatic grp_t cla_group(input logic [MAX_BLOCK-1:0] a,
                                     input logic [MAX_BLOCK-1:0] b,
                                     input logic c,
                                     input int n);
    grp_t r;
    logic cc;
    r   = '0;
    r.p = 1'b1;
    cc  = c;
    for (int i = 0; i < MAX_BLOCK; i++) begin
      if (i < n) begin
        r.sum[i] = a[i] ^ b[i] ^ cc;
        cc       = (a[i] & b[i]) | ((a[i] ^ b[i]) & cc);
        r.g      = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.g);
        r.p      = r.p & (a[i] ^ b[i]);
      end
    end
    return r;
  endfunction

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int groups(input int sw, input int block);
    return sw / block;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead slice: BLOCK-bit groups joined by a
// group-level lookahead carry chain.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SW    = 16,
  parameter int BLOCK = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_top
);

  localparam int GROUPS = groups(SW, BLOCK);

  logic [GROUPS:0] gc;

  always_comb begin
    grp_t                 r_gp;
    grp_t                 r_sum;
    logic [MAX_BLOCK-1:0] ea;
    logic [MAX_BLOCK-1:0] eb;
    gc    = '0;
    sum   = '0;
    gc[0] = cin;
    for (int g = 0; g < GROUPS; g++) begin
      ea = '0;
      eb = '0;
      ea[BLOCK-1:0] = a[g*BLOCK +: BLOCK];
      eb[BLOCK-1:0] = b[g*BLOCK +: BLOCK];
      // G/P do not depend on the incoming carry, so the group carries resolve first.
      r_gp      = cla_group(ea, eb, 1'b0, BLOCK);
      gc[g+1]   = r_gp.g | (r_gp.p & gc[g]);
      r_sum     = cla_group(ea, eb, gc[g], BLOCK);
      sum[g*BLOCK +: BLOCK] = r_sum.sum[BLOCK-1:0];
    end
  end

  assign cout  = gc[GROUPS];
  // Carry into the top bit recovered from its sum bit.
  assign c_top = sum[SW-1] ^ a[SW-1] ^ b[SW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: STAGES registered slices, carry crossing
// slice boundaries through registers, valid/ready on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (WIDTH % (BLOCK * STAGES) != 0) begin : g_bad_geometry
    $fatal(1, "WIDTH must be a multiple of BLOCK*STAGES");
  end
  if (BLOCK > MAX_BLOCK) begin : g_bad_block
    $fatal(1, "BLOCK exceeds MAX_BLOCK");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             msbc;
  } pay_t;

  // Handshake: a beat moves into stage k when adv[k]; adv ripples back from
  // the output so a stage frees up in the same cycle its occupant leaves.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;

  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0] && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pay_t        src;
    pay_t        nxt;
    pay_t        pq;
    logic        vin;
    logic        vq;
    logic [SW-1:0] s_sum;
    logic        s_cout;
    logic        s_ctop;

    if (k == 0) begin : g_head
      // Subtraction folds in here: invert B and the carry-in once at entry.
      assign src = '{a: a, b: b ^ {WIDTH{sub}}, sum: '0, carry: cin ^ sub, msbc: 1'b0};
      assign vin = in_valid;
    end else begin : g_body
      assign src = g_stage[k-1].pq;
      assign vin = v[k-1];
    end

    cla_slice #(.SW(SW), .BLOCK(BLOCK)) u_slice (
      .a    (src.a[k*SW +: SW]),
      .b    (src.b[k*SW +: SW]),
      .cin  (src.carry),
      .sum  (s_sum),
      .cout (s_cout),
      .c_top(s_ctop)
    );

    always_comb begin
      nxt                  = src;
      nxt.sum[k*SW +: SW]  = s_sum;
      nxt.carry            = s_cout;
      nxt.msbc             = s_ctop;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vq <= 1'b0;
        pq <= '0;
      end else if (adv[k]) begin
        vq <= vin;
        pq <= nxt;
      end
    end

    assign v[k] = vq;
  end

  assign out_valid = v[STAGES-1];
  assign sum       = g_stage[STAGES-1].pq.sum;
  assign cout      = g_stage[STAGES-1].pq.carry;
  assign ovf       = g_stage[STAGES-1].pq.msbc ^ g_stage[STAGES-1].pq.carry;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed corner beats, stall,
// mid-flight reset and randomized traffic against an integer reference model.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] held_v;
  bit           held_ok = 1'b0;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference: signed/unsigned integer arithmetic, result as {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    longint ua, ub, sa, sb, ru, rs, lim, c;
    logic   co, ov;
    ua = 0; ub = 0;
    ua[W-1:0] = ma;
    ub[W-1:0] = mb;
    c   = mc ? 64'sd1 : 64'sd0;
    lim = longint'(1) <<< (W - 1);
    sa  = ma[W-1] ? ua - (lim <<< 1) : ua;
    sb  = mb[W-1] ? ub - (lim <<< 1) : ub;
    if (!ms) begin
      ru = ua + ub + c;
      rs = sa + sb + c;
      co = (ru >= (lim <<< 1));
    end else begin
      ru = ua - ub - c;
      rs = sa - sb - c;
      co = (ua >= ub + c);
    end
    ov = (rs >= lim) || (rs < -lim);
    return {co, ov, ru[W-1:0]};
  endfunction

  // Driver: advance to posedge+1, optionally randomizing backpressure.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts, input logic [W+1:0] e);
    bit done = 1'b0;
    in_valid = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    for (int t = 0; t < 1000 && !done; t++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W+1:0] act;
    if (rst) begin
      held_ok = 1'b0;
    end else if (out_valid) begin
      act = {cout, ovf, sum};
      if (held_ok) chk("hold_stable", act, held_v);
      if (out_ready) begin
        held_ok = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %h, required no result", act);
        end else begin
          chk("result", act, exp_q.pop_front());
        end
      end else begin
        held_ok = 1'b1;
        held_v  = act;
      end
    end else begin
      held_ok = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {33'b0, out_valid}, '0);
    chk("rst_in_ready", {33'b0, in_ready}, '0);
    chk("rst_sum_cout_ovf", {cout, ovf, sum}, '0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Carry out of MSB, with latency check
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h2_0000_0000);
    chk("latency_minus1", {33'b0, out_valid}, '0);
    step();
    chk("latency_exact", {33'b0, out_valid}, 34'd1);

    // Directed corners
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h1_8000_0000);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 34'h0_FFFF_FFFE);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 34'h0_FFFF_FFFD);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 34'h3_0000_0000);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 34'h2_0000_0000);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 34'h3_7FFF_FFFF);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 34'h0_0001_0001);
    repeat (4) step();

    // Full stall: two beats fill the pipe, third is refused until release
    out_ready = 1'b0;
    step();
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0));
    send(32'h3333_3333, 32'h0000_0003, 1'b1, 1'b1, model(32'h3333_3333, 32'h0000_0003, 1'b1, 1'b1));
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; sub = 1'b0;
    #1;
    chk("stall_in_ready", {33'b0, in_ready}, '0);
    step();
    step();
    chk("stall_out_valid", {33'b0, out_valid}, 34'd1);
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0));
    repeat (4) step();

    // Mid-flight reset discards in-flight beats
    out_ready = 1'b0;
    send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, model(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0));
    send(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, model(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {33'b0, out_valid}, '0);
    chk("midrst_in_ready", {33'b0, in_ready}, '0);
    chk("midrst_sum", {cout, ovf, sum}, '0);
    exp_q.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", {33'b0, out_valid}, '0);
    end
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1));

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Drain
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) step();
    step();
    chk("drain_empty", 34'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
